// File: rtl/rv_pkg.sv
// Shared RV32I execute-stage definitions: datapath width and the control
// encodings exchanged between decode, execute and the hazard unit.
package rv_pkg;

  localparam int unsigned XLEN = 32;

  // ALUControl encodings; any code not listed here behaves as add.
  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_AND = 3'b010,
    ALU_OR  = 3'b011,
    ALU_SLT = 3'b101
  } alu_ctrl_e;

  // ResultSrc encodings, selected in writeback.
  typedef enum logic [1:0] {
    RES_ALU = 2'b00,
    RES_MEM = 2'b01,
    RES_PC4 = 2'b10
  } result_src_e;

  // Forward mux selects; 2'b11 falls back to the register-file operand.
  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_WB  = 2'b01,
    FWD_MEM = 2'b10
  } fwd_sel_e;

endpackage

// File: rtl/execute_cycle_alu.sv
// Combinational ALU of the execute stage.
// Ports:
//   src_a_i, src_b_i  operands
//   alu_ctrl_i        operation (rv_pkg::alu_ctrl_e encoding, unknown -> add)
//   result_o          result, add/sub wrap mod 2^XLEN
//   zero_o            result == 0 (used for beq)
module alu
  import rv_pkg::*;
#(
  parameter int unsigned XLEN = rv_pkg::XLEN
) (
  input  logic [XLEN-1:0] src_a_i,
  input  logic [XLEN-1:0] src_b_i,
  input  logic [2:0]      alu_ctrl_i,
  output logic [XLEN-1:0] result_o,
  output logic            zero_o
);

  logic lt;

  assign lt = $signed(src_a_i) < $signed(src_b_i);

  always_comb begin
    result_o = src_a_i + src_b_i;
    case (alu_ctrl_i)
      ALU_SUB: result_o = src_a_i - src_b_i;
      ALU_AND: result_o = src_a_i & src_b_i;
      ALU_OR:  result_o = src_a_i | src_b_i;
      ALU_SLT: result_o = {{(XLEN-1){1'b0}}, lt};
      default: result_o = src_a_i + src_b_i;
    endcase
  end

  assign zero_o = (result_o == '0);

endmodule

// File: rtl/execute_cycle.sv
// Execute stage of the 5-stage RV32I pipeline: operand forwarding, ALU,
// beq/jal resolution back to fetch, and the EX/MEM pipeline register.
// Ports:
//   clk, rst            clock; asynchronous active-low reset
//   *_E inputs          ID/EX register contents from decode
//   ResultW             writeback result (forward source)
//   ForwardA_E/B_E      forward selects (rv_pkg::fwd_sel_e)
//   PCSrc_E, PCTarget_E combinational redirect to fetch
//   *_M outputs         EX/MEM register, one cycle after the *_E values
//   BrCnt_o, TakenCnt_o branch/jump and taken-redirect counters
// Optional feature: define EXEC_PERF_CNT_EN to build the counters; otherwise
// BrCnt_o and TakenCnt_o are tied to zero.
module execute_cycle
  import rv_pkg::*;
#(
  parameter int unsigned XLEN  = rv_pkg::XLEN,
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             RegWrite_E,
  input  logic             MemWrite_E,
  input  logic             ALUSrc_E,
  input  logic             Branch_E,
  input  logic             Jump_E,
  input  logic [1:0]       ResultSrc_E,
  input  logic [2:0]       ALUControl_E,
  input  logic [XLEN-1:0]  RD1_E,
  input  logic [XLEN-1:0]  RD2_E,
  input  logic [XLEN-1:0]  PC_E,
  input  logic [XLEN-1:0]  PCPlus4_E,
  input  logic [XLEN-1:0]  ImmExt_E,
  input  logic [4:0]       Rd_E,
  input  logic [XLEN-1:0]  ResultW,
  input  logic [1:0]       ForwardA_E,
  input  logic [1:0]       ForwardB_E,
  output logic             PCSrc_E,
  output logic [XLEN-1:0]  PCTarget_E,
  output logic             RegWrite_M,
  output logic             MemWrite_M,
  output logic [1:0]       ResultSrc_M,
  output logic [4:0]       Rd_M,
  output logic [XLEN-1:0]  ALUResult_M,
  output logic [XLEN-1:0]  WriteData_M,
  output logic [XLEN-1:0]  PCPlus4_M,
  output logic [CNT_W-1:0] BrCnt_o,
  output logic [CNT_W-1:0] TakenCnt_o
);

  logic [XLEN-1:0] src_a, src_b, write_data, alu_result_d;
  logic            zero;

  logic            reg_write_q, mem_write_q;
  logic [1:0]      result_src_q;
  logic [4:0]      rd_q;
  logic [XLEN-1:0] alu_result_q, write_data_q, pc_plus4_q;

  // Forward muxes; the MEM-stage source is this block's own EX/MEM register.
  always_comb begin
    src_a = RD1_E;
    case (ForwardA_E)
      FWD_WB:  src_a = ResultW;
      FWD_MEM: src_a = alu_result_q;
      default: src_a = RD1_E;
    endcase
  end

  always_comb begin
    write_data = RD2_E;
    case (ForwardB_E)
      FWD_WB:  write_data = ResultW;
      FWD_MEM: write_data = alu_result_q;
      default: write_data = RD2_E;
    endcase
  end

  assign src_b = ALUSrc_E ? ImmExt_E : write_data;

  alu #(.XLEN(XLEN)) u_alu (
    .src_a_i    (src_a),
    .src_b_i    (src_b),
    .alu_ctrl_i (ALUControl_E),
    .result_o   (alu_result_d),
    .zero_o     (zero)
  );

  assign PCSrc_E    = Jump_E | (Branch_E & zero);
  assign PCTarget_E = PC_E + ImmExt_E;

  // EX/MEM register: no enable, no flush; bubbles arrive with zero controls.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      reg_write_q  <= 1'b0;
      mem_write_q  <= 1'b0;
      result_src_q <= '0;
      rd_q         <= '0;
      alu_result_q <= '0;
      write_data_q <= '0;
      pc_plus4_q   <= '0;
    end else begin
      reg_write_q  <= RegWrite_E;
      mem_write_q  <= MemWrite_E;
      result_src_q <= ResultSrc_E;
      rd_q         <= Rd_E;
      alu_result_q <= alu_result_d;
      write_data_q <= write_data;
      pc_plus4_q   <= PCPlus4_E;
    end
  end

  assign RegWrite_M  = reg_write_q;
  assign MemWrite_M  = mem_write_q;
  assign ResultSrc_M = result_src_q;
  assign Rd_M        = rd_q;
  assign ALUResult_M = alu_result_q;
  assign WriteData_M = write_data_q;
  assign PCPlus4_M   = pc_plus4_q;

`ifdef EXEC_PERF_CNT_EN
  logic [CNT_W-1:0] br_cnt_q, taken_cnt_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      br_cnt_q    <= '0;
      taken_cnt_q <= '0;
    end else begin
      if (Branch_E | Jump_E) br_cnt_q    <= br_cnt_q + CNT_W'(1);
      if (PCSrc_E)           taken_cnt_q <= taken_cnt_q + CNT_W'(1);
    end
  end

  assign BrCnt_o    = br_cnt_q;
  assign TakenCnt_o = taken_cnt_q;
`else
  assign BrCnt_o    = '0;
  assign TakenCnt_o = '0;
`endif

endmodule

// File: tb/tb_execute_cycle.sv
// Directed bench for execute_cycle: a table of instructions with
// hand-computed results, followed by reset and latency sequences.
module tb_execute_cycle;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned CNT_W = 32;

  logic             clk = 1'b0;
  logic             rst;
  logic             RegWrite_E, MemWrite_E, ALUSrc_E, Branch_E, Jump_E;
  logic [1:0]       ResultSrc_E, ForwardA_E, ForwardB_E;
  logic [2:0]       ALUControl_E;
  logic [XLEN-1:0]  RD1_E, RD2_E, PC_E, PCPlus4_E, ImmExt_E, ResultW;
  logic [4:0]       Rd_E;
  logic             PCSrc_E;
  logic [XLEN-1:0]  PCTarget_E;
  logic             RegWrite_M, MemWrite_M;
  logic [1:0]       ResultSrc_M;
  logic [4:0]       Rd_M;
  logic [XLEN-1:0]  ALUResult_M, WriteData_M, PCPlus4_M;
  logic [CNT_W-1:0] BrCnt_o, TakenCnt_o;

  execute_cycle #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .RegWrite_E(RegWrite_E), .MemWrite_E(MemWrite_E), .ALUSrc_E(ALUSrc_E),
    .Branch_E(Branch_E), .Jump_E(Jump_E), .ResultSrc_E(ResultSrc_E),
    .ALUControl_E(ALUControl_E), .RD1_E(RD1_E), .RD2_E(RD2_E), .PC_E(PC_E),
    .PCPlus4_E(PCPlus4_E), .ImmExt_E(ImmExt_E), .Rd_E(Rd_E), .ResultW(ResultW),
    .ForwardA_E(ForwardA_E), .ForwardB_E(ForwardB_E),
    .PCSrc_E(PCSrc_E), .PCTarget_E(PCTarget_E),
    .RegWrite_M(RegWrite_M), .MemWrite_M(MemWrite_M), .ResultSrc_M(ResultSrc_M),
    .Rd_M(Rd_M), .ALUResult_M(ALUResult_M), .WriteData_M(WriteData_M),
    .PCPlus4_M(PCPlus4_M), .BrCnt_o(BrCnt_o), .TakenCnt_o(TakenCnt_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0]  fa, fb;
    logic        alusrc;
    logic [2:0]  ctl;
    logic        br, jmp, rw, mw;
    logic [1:0]  rs;
    logic [4:0]  rd;
    logic [31:0] rd1, rd2, imm, pc, pcp4, resw;
    logic        e_pcsrc;
    logic [31:0] e_target, e_alu, e_wd;
  } vec_t;

  vec_t vecs[$];
  int   tests = 0;
  int   fails = 0;
  int   exp_br = 0;
  int   exp_taken = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    ForwardA_E = v.fa;   ForwardB_E = v.fb;   ALUSrc_E = v.alusrc;
    ALUControl_E = v.ctl; Branch_E = v.br;    Jump_E = v.jmp;
    RegWrite_E = v.rw;   MemWrite_E = v.mw;   ResultSrc_E = v.rs;
    Rd_E = v.rd;         RD1_E = v.rd1;       RD2_E = v.rd2;
    ImmExt_E = v.imm;    PC_E = v.pc;         PCPlus4_E = v.pcp4;
    ResultW = v.resw;
  endtask

  task automatic check_m_zero(input string tag);
    check({tag, "_alu"}, ALUResult_M, 32'h0);
    check({tag, "_wd"},  WriteData_M, 32'h0);
    check({tag, "_pc4"}, PCPlus4_M,   32'h0);
    check({tag, "_ctl"}, {22'd0, RegWrite_M, MemWrite_M, ResultSrc_M, Rd_M}, 32'h0);
    check({tag, "_brcnt"},    BrCnt_o,    32'h0);
    check({tag, "_takencnt"}, TakenCnt_o, 32'h0);
  endtask

  initial begin
    vec_t v;

    // 0: add imm 5+7, Rd=3
    v = '0; v.rd1 = 5; v.imm = 7; v.alusrc = 1; v.rd = 3; v.rw = 1; v.pcp4 = 4;
    v.e_target = 7; v.e_alu = 12; v.e_wd = 0; vecs.push_back(v);
    // 1: add 8+8 -> 0x10, Rd=x0 passes through
    v = '0; v.rd1 = 8; v.rd2 = 8; v.rw = 1; v.rd = 0; v.pc = 32'h10;
    v.e_target = 32'h10; v.e_alu = 32'h10; v.e_wd = 8; vecs.push_back(v);
    // 2: forward A from ALUResult_M (0x10), B from ResultW (0x20), sub
    v = '0; v.fa = 2'b10; v.fb = 2'b01; v.rd1 = 32'hFF; v.rd2 = 32'h55; v.resw = 32'h20;
    v.ctl = 3'b001; v.pc = 32'h20; v.imm = 4; v.rd = 7; v.rw = 1;
    v.e_target = 32'h24; v.e_alu = 32'hFFFF_FFF0; v.e_wd = 32'h20; vecs.push_back(v);
    // 3: beq taken
    v = '0; v.rd1 = 9; v.rd2 = 9; v.br = 1; v.ctl = 3'b001; v.pc = 32'h100; v.imm = 32'hFFFF_FFF8;
    v.e_pcsrc = 1; v.e_target = 32'hF8; v.e_alu = 0; v.e_wd = 9; vecs.push_back(v);
    // 4: beq not taken
    v = '0; v.rd1 = 9; v.rd2 = 8; v.br = 1; v.ctl = 3'b001; v.pc = 32'h100; v.imm = 32'hFFFF_FFF8;
    v.e_pcsrc = 0; v.e_target = 32'hF8; v.e_alu = 1; v.e_wd = 8; vecs.push_back(v);
    // 5: jal
    v = '0; v.jmp = 1; v.pc = 32'h40; v.imm = 32'h20; v.rs = 2'b10; v.pcp4 = 32'h44; v.rw = 1; v.rd = 1;
    v.e_pcsrc = 1; v.e_target = 32'h60; v.e_alu = 0; v.e_wd = 0; vecs.push_back(v);
    // 6: slt -1 < 1
    v = '0; v.rd1 = 32'hFFFF_FFFF; v.rd2 = 1; v.ctl = 3'b101; v.rw = 1; v.rd = 4;
    v.e_alu = 1; v.e_wd = 1; vecs.push_back(v);
    // 7: slt 1 < -1 false
    v = '0; v.rd1 = 1; v.rd2 = 32'hFFFF_FFFF; v.ctl = 3'b101; v.rw = 1; v.rd = 4;
    v.e_alu = 0; v.e_wd = 32'hFFFF_FFFF; vecs.push_back(v);
    // 8: and
    v = '0; v.rd1 = 32'hF0F0; v.rd2 = 32'hFF00; v.ctl = 3'b010; v.rw = 1; v.rd = 5;
    v.e_alu = 32'hF000; v.e_wd = 32'hFF00; vecs.push_back(v);
    // 9: or
    v = '0; v.rd1 = 32'hF0F0; v.rd2 = 32'hFF00; v.ctl = 3'b011; v.rw = 1; v.rd = 5;
    v.e_alu = 32'hFFF0; v.e_wd = 32'hFF00; vecs.push_back(v);
    // 10: sub wrap 0-1, target wrap
    v = '0; v.rd1 = 0; v.rd2 = 1; v.ctl = 3'b001; v.pc = 32'hFFFF_FFFC; v.imm = 8; v.rd = 31; v.rw = 1;
    v.e_target = 4; v.e_alu = 32'hFFFF_FFFF; v.e_wd = 1; vecs.push_back(v);
    // 11: undefined control code behaves as add
    v = '0; v.rd1 = 3; v.rd2 = 4; v.ctl = 3'b111; v.rw = 1; v.rd = 6;
    v.e_alu = 7; v.e_wd = 4; vecs.push_back(v);
    // 12: ForwardA=11 -> RD1, ForwardB=10 -> ALUResult_M (7)
    v = '0; v.fa = 2'b11; v.fb = 2'b10; v.rd1 = 2; v.rd2 = 32'h99; v.mw = 1; v.rs = 2'b01;
    v.e_alu = 9; v.e_wd = 7; vecs.push_back(v);
    // 13: store with imm offset; store data forwarded from ALUResult_M (9)
    v = '0; v.fb = 2'b10; v.rd1 = 32'h100; v.imm = 4; v.alusrc = 1; v.mw = 1; v.rd = 2;
    v.e_target = 4; v.e_alu = 32'h104; v.e_wd = 9; vecs.push_back(v);

    rst = 1'b0;
    drive('0);
    #1;
    check_m_zero("reset_init");
    @(negedge clk);
    rst = 1'b1;

    foreach (vecs[i]) begin
      @(negedge clk);
      drive(vecs[i]);
      #1;
      check($sformatf("v%0d_pcsrc", i),  {31'd0, PCSrc_E}, {31'd0, vecs[i].e_pcsrc});
      check($sformatf("v%0d_target", i), PCTarget_E, vecs[i].e_target);
      @(posedge clk);
      #1;
      if (vecs[i].br | vecs[i].jmp) exp_br++;
      if (vecs[i].e_pcsrc) exp_taken++;
      check($sformatf("v%0d_alu", i), ALUResult_M, vecs[i].e_alu);
      check($sformatf("v%0d_wd", i),  WriteData_M, vecs[i].e_wd);
      check($sformatf("v%0d_pc4", i), PCPlus4_M, vecs[i].pcp4);
      check($sformatf("v%0d_ctl", i), {22'd0, RegWrite_M, MemWrite_M, ResultSrc_M, Rd_M},
            {22'd0, vecs[i].rw, vecs[i].mw, vecs[i].rs, vecs[i].rd});
    end

`ifdef EXEC_PERF_CNT_EN
    check("brcnt",    BrCnt_o,    exp_br);
    check("takencnt", TakenCnt_o, exp_taken);
    check("brcnt_is3",    BrCnt_o,    32'd3);
    check("takencnt_is2", TakenCnt_o, 32'd2);
`else
    check("brcnt_off",    BrCnt_o,    32'd0);
    check("takencnt_off", TakenCnt_o, 32'd0);
`endif

    // Mid-cycle asynchronous reset clears state before the next edge.
    @(negedge clk);
    v = '0; v.rd1 = 1; v.rd2 = 1; v.rw = 1; v.rd = 9; v.pcp4 = 32'h88; v.jmp = 1;
    drive(v);
    @(posedge clk);
    #1;
    check("pre_reset_alu", ALUResult_M, 32'd2);
    #2;
    rst = 1'b0;
    #1;
    check_m_zero("async_reset");
    // An edge while held in reset must not latch the in-flight instruction.
    @(posedge clk);
    #1;
    check_m_zero("held_reset");
    @(negedge clk);
    rst = 1'b1;
    drive('0);
    @(posedge clk);
    #1;
    check_m_zero("after_release");

    // One-cycle latency: result invisible before the edge, visible after.
    @(negedge clk);
    v = '0; v.rd1 = 20; v.rd2 = 22; v.rw = 1; v.rd = 10;
    drive(v);
    #1;
    check("latency_before", ALUResult_M, 32'd0);
    @(posedge clk);
    #1;
    check("latency_after", ALUResult_M, 32'd42);
    check("latency_rd", {27'd0, Rd_M}, 32'd10);
    @(negedge clk);
    drive('0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: simulation did not finish within 20000 time units");
    $fatal(1);
  end

endmodule
